time_keeper: RTL

Time-of-day counter for the digital clock. Keeps hours, minutes, seconds and centiseconds in packed BCD and presents them as the 32-bit word consumed by the hex display multiplexer (eight 4-bit digits, digit 0 at bits 3:0). Also accepts the user set controls (run/pause, hour/minute increment, seconds clear) from the debounced button front end.

---
 rtl/time_keeper.sv | 120 ++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Time-of-day counter: HH:MM:SS.CC in packed BCD, advanced by a centisecond
// prescaler, with user set controls that pre-empt a coincident tick.
module time_keeper #(
  parameter int CLK_FREQ_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        clr_sec,
  output logic [31:0] all_data,
  output logic        day_wrap
);

  localparam int DIV = CLK_FREQ_HZ / 100;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hours_q, hours_d;
  logic [7:0]    mins_q, mins_d;
  logic [7:0]    secs_q, secs_d;
  logic [7:0]    centis_q, centis_d;
  logic          dayWrap_q, dayWrap_d;

  logic          tick;
  logic          anySet;
  logic          advance;
  logic [8:0]    centisInc, secsInc, minsInc, hoursInc;

  // Returns {carry, next} for a two-digit BCD field that wraps to 00 after maxV.
  function automatic logic [8:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
    logic [3:0] tensNext;
    logic [3:0] unitsNext;
    tensNext  = v[7:4] + 4'd1;
    unitsNext = v[3:0] + 4'd1;
    if (v == maxV) begin
      return 9'h100;
    end else if (v[3:0] == 4'd9) begin
      return {1'b0, tensNext, 4'd0};
    end else begin
      return {1'b0, v[7:4], unitsNext};
    end
  endfunction

  assign tick    = run && (presc_q == PRE_MAX);
  assign anySet  = inc_hour || inc_min || clr_sec;
  assign advance = tick && !anySet;

  always_comb begin
    presc_d = presc_q;
    if (clr_sec || tick) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // A set input in the tick cycle swallows the tick entirely, so the carry
  // chain and the set controls never touch the same field in one cycle.
  always_comb begin
    hours_d   = hours_q;
    mins_d    = mins_q;
    secs_d    = secs_q;
    centis_d  = centis_q;
    dayWrap_d = 1'b0;
    centisInc = bcdInc(centis_q, 8'h99);
    secsInc   = bcdInc(secs_q, 8'h59);
    minsInc   = bcdInc(mins_q, 8'h59);
    hoursInc  = bcdInc(hours_q, 8'h23);

    if (advance) begin
      centis_d = centisInc[7:0];
      if (centisInc[8]) begin
        secs_d = secsInc[7:0];
        if (secsInc[8]) begin
          mins_d = minsInc[7:0];
          if (minsInc[8]) begin
            hours_d   = hoursInc[7:0];
            dayWrap_d = hoursInc[8];
          end
        end
      end
    end

    if (inc_hour) begin
      hours_d = hoursInc[7:0];
    end
    if (inc_min) begin
      mins_d = minsInc[7:0];
    end
    if (clr_sec) begin
      secs_d   = 8'h00;
      centis_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      hours_q   <= 8'h00;
      mins_q    <= 8'h00;
      secs_q    <= 8'h00;
      centis_q  <= 8'h00;
      dayWrap_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hours_q   <= hours_d;
      mins_q    <= mins_d;
      secs_q    <= secs_d;
      centis_q  <= centis_d;
      dayWrap_q <= dayWrap_d;
    end
  end

  assign all_data = {hours_q, mins_q, secs_q, centis_q};
  assign day_wrap = dayWrap_q;

endmodule
